// File: rtl/register_ops_pkg.sv
// Shared op codes and FSM encoding for the bit-manipulation register.
package register_ops_pkg;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_LOAD    = 3'b001;
  localparam logic [2:0] OP_REVERSE = 3'b010;
  localparam logic [2:0] OP_SWAP    = 3'b011;
  localparam logic [2:0] OP_ROTL    = 3'b100;
  localparam logic [2:0] OP_ROTR    = 3'b101;
  localparam logic [2:0] OP_SHL     = 3'b110;
  localparam logic [2:0] OP_SAR     = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The top opcode bit marks the ops that take one clock per bit position.
  function automatic logic is_iterative(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/register_n_ops_if.sv
// Request/response bundle between a controller and register_n_ops.
interface register_n_ops_if #(
  parameter int WIDTH = 8
);
  localparam int AMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] i;
  logic [2:0]       op;
  logic             op_valid;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;

  modport master (
    output i, op, op_valid, amount,
    input  data, busy, done
  );

  modport slave (
    input  i, op, op_valid, amount,
    output data, busy, done
  );
endinterface

// File: rtl/register_step_unit.sv
// Combinational one-step transform: reverse, half-swap, or a single-bit
// rotate/shift. Any other op passes the word through unchanged.
module register_step_unit
  import register_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);
  localparam int HALF = WIDTH / 2;

  // NOTE: data_o gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    data_o = data_i;
    case (op_i)
      OP_REVERSE: begin
        for (int k = 0; k < WIDTH; k++) begin
          data_o[k] = data_i[WIDTH-1-k];
        end
      end
      OP_SWAP: data_o = {data_i[HALF-1:0], data_i[WIDTH-1:HALF]};
      OP_ROTL: data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      OP_ROTR: data_o = {data_i[0], data_i[WIDTH-1:1]};
      OP_SHL:  data_o = {data_i[WIDTH-2:0], 1'b0};
      OP_SAR:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/register_n_ops.sv
// WIDTH-bit bit-manipulation register: single-cycle load/reverse/swap and
// iterative rotate/shift, with a start/busy/done handshake.
module register_n_ops
  import register_ops_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  register_n_ops_if.slave bus
);
  localparam int AMT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [AMT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic             done_q,  done_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_data;

  // In RUN the latched op drives the step unit; the live bus op is a don't-care.
  assign step_op = (state_q == ST_RUN) ? op_q : bus.op;

  register_step_unit #(.WIDTH(WIDTH)) u_step (
    .op_i   (step_op),
    .data_i (data_q),
    .data_o (step_data)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          if (!is_iterative(bus.op)) begin
            done_d = 1'b1;
            case (bus.op)
              OP_LOAD:           data_d = bus.i;
              OP_REVERSE, OP_SWAP: data_d = step_data;
              default:           data_d = data_q;
            endcase
          end else if (bus.amount == '0) begin
            done_d = 1'b1;
          end else begin
            op_d    = bus.op;
            cnt_d   = bus.amount;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        data_d = step_data;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign bus.data = data_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_register_n_ops.sv
// Directed bench for register_n_ops (WIDTH=8 and WIDTH=16) with a result scoreboard.
module tb_register_n_ops;
  import register_ops_pkg::*;

  logic clk;
  logic rst;

  register_n_ops_if #(.WIDTH(8))  b8 ();
  register_n_ops_if #(.WIDTH(16)) b16 ();

  register_n_ops #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  register_n_ops #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] step_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on b8, then follow it to its done pulse (bounded).
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] din,
                        input logic [2:0] amt, input logic [7:0] exp, input bit poke);
    int edges;
    bit got;
    b8.op       = op;
    b8.i        = din;
    b8.amount   = amt;
    b8.op_valid = 1'b1;
    exp_q.push_back(exp);
    edges = 0;
    got   = 1'b0;
    tick();
    edges++;
    b8.op       = OP_LOAD;
    b8.i        = 8'hFF;
    b8.amount   = ~amt;
    b8.op_valid = poke;
    while (!got && edges < 64) begin
      check({tag, " busy&done"}, 32'(b8.busy & b8.done), 32'd0);
      if (b8.done) begin
        got = 1'b1;
        b8.op_valid = 1'b0;
        check({tag, " data"}, 32'(b8.data), 32'(exp_q.pop_front()));
      end else begin
        if (b8.busy && step_q.size() > 0)
          check({tag, " step"}, 32'(b8.data), 32'(step_q.pop_front()));
        tick();
        edges++;
      end
    end
    b8.op_valid = 1'b0;
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(edges), op[2] ? 32'(amt) + 32'd1 : 32'd1);
  endtask

  initial begin
    int dones;
    rst          = 1'b1;
    b8.op        = OP_LOAD;
    b8.i         = 8'hFF;
    b8.amount    = '0;
    b8.op_valid  = 1'b1;
    b16.op       = OP_LOAD;
    b16.i        = 16'hFFFF;
    b16.amount   = '0;
    b16.op_valid = 1'b1;
    repeat (2) tick();
    check("reset data", 32'(b8.data), 32'h00);
    check("reset busy", 32'(b8.busy), 32'd0);
    check("reset done", 32'(b8.done), 32'd0);
    check("reset data16", 32'(b16.data), 32'h0000);
    rst          = 1'b0;
    b8.op_valid  = 1'b0;
    b16.op_valid = 1'b0;
    tick();
    check("idle data", 32'(b8.data), 32'h00);

    // Single-cycle ops, each issued on the previous done cycle.
    run_op("load", OP_LOAD, 8'hB4, 3'd0, 8'hB4, 1'b0);
    run_op("reverse", OP_REVERSE, 8'h00, 3'd0, 8'h2D, 1'b0);
    run_op("reload", OP_LOAD, 8'hB4, 3'd0, 8'hB4, 1'b0);
    run_op("swap", OP_SWAP, 8'h00, 3'd0, 8'h4B, 1'b0);
    run_op("nop", OP_NOP, 8'h77, 3'd0, 8'h4B, 1'b0);
    tick();
    check("done single pulse", 32'(b8.done), 32'd0);

    // ROTL by 3 with a LOAD request held high throughout the run.
    run_op("load rotl", OP_LOAD, 8'hB4, 3'd0, 8'hB4, 1'b0);
    step_q.push_back(8'hB4);
    step_q.push_back(8'h69);
    step_q.push_back(8'hD2);
    run_op("rotl3", OP_ROTL, 8'h00, 3'd3, 8'hA5, 1'b1);
    check("rotl steps used", 32'(step_q.size()), 32'd0);
    tick();
    check("rotl done pulse", 32'(b8.done), 32'd0);
    check("rotl hold", 32'(b8.data), 32'hA5);

    run_op("load sar", OP_LOAD, 8'h84, 3'd0, 8'h84, 1'b0);
    step_q.push_back(8'h84);
    step_q.push_back(8'hC2);
    run_op("sar2", OP_SAR, 8'h00, 3'd2, 8'hE1, 1'b0);
    run_op("shl0", OP_SHL, 8'h00, 3'd0, 8'hE1, 1'b0);
    check("shl0 busy", 32'(b8.busy), 32'd0);

    run_op("load shl7", OP_LOAD, 8'h35, 3'd0, 8'h35, 1'b0);
    run_op("shl7", OP_SHL, 8'h00, 3'd7, 8'h80, 1'b0);
    run_op("load sar7", OP_LOAD, 8'hA6, 3'd0, 8'hA6, 1'b0);
    run_op("sar7", OP_SAR, 8'h00, 3'd7, 8'hFF, 1'b0);
    run_op("load rotr", OP_LOAD, 8'h01, 3'd0, 8'h01, 1'b0);
    run_op("rotr1", OP_ROTR, 8'h00, 3'd1, 8'h80, 1'b0);
    tick();

    // ROTR by 5 aborted by reset after the second step.
    run_op("load abort", OP_LOAD, 8'h01, 3'd0, 8'h01, 1'b0);
    tick();
    b8.op       = OP_ROTR;
    b8.amount   = 3'd5;
    b8.op_valid = 1'b1;
    tick();
    b8.op_valid = 1'b0;
    check("abort accept busy", 32'(b8.busy), 32'd1);
    check("abort accept data", 32'(b8.data), 32'h01);
    tick();
    check("abort step1", 32'(b8.data), 32'h80);
    tick();
    check("abort step2", 32'(b8.data), 32'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort data", 32'(b8.data), 32'h00);
    check("abort busy", 32'(b8.busy), 32'd0);
    check("abort done", 32'(b8.done), 32'd0);
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (b8.done || b8.busy) dones++;
      tick();
    end
    check("abort quiet", 32'(dones), 32'd0);

    // 16-bit instance: load then swap on the done cycle.
    b16.op       = OP_LOAD;
    b16.i        = 16'h12AB;
    b16.op_valid = 1'b1;
    tick();
    check("w16 load done", 32'(b16.done), 32'd1);
    check("w16 load data", 32'(b16.data), 32'h12AB);
    b16.op = OP_SWAP;
    b16.i  = 16'h0000;
    tick();
    b16.op_valid = 1'b0;
    check("w16 swap done", 32'(b16.done), 32'd1);
    check("w16 swap data", 32'(b16.data), 32'hAB12);
    tick();
    check("w16 done pulse", 32'(b16.done), 32'd0);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_n_ops.md
Name: register_n_ops

Overview:
- Parametrised successor to the 8-bit load/reverse/nibble/rotate register.
- Holds a WIDTH-bit word and applies opcode-selected transforms:
  - single-cycle: load, bit-reverse, half-swap;
  - iterative: rotate/shift by a run-time amount, one bit position per clock.
- Sits in the datapath as a general bit-manipulation register with a start/busy/done handshake toward its controller.

Parameters:
- WIDTH, 8, data width; must be even and >= 4.
- AMT_W, $clog2(WIDTH), width of the shift/rotate amount field (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- i  in  WIDTH  load operand.
- op  in  3  operation code (see Behaviour).
- op_valid  in  1  request strobe, sampled on the rising edge of clk.
- amount  in  AMT_W  step count for iterative ops.
- data  out  WIDTH  register contents.
- busy  out  1  iterative op in progress; requests are ignored while high.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge) overrides everything:
  - data=0, busy=0, done=0, step counter=0, state=IDLE.
  - Reset mid-operation aborts the op; no done pulse is issued.
- Op codes:
  - 000 NOP.
  - 001 LOAD: data<=i.
  - 010 REVERSE: data[k]<=data[WIDTH-1-k].
  - 011 SWAP: upper and lower halves exchanged.
  - 100 ROTL.
  - 101 ROTR.
  - 110 SHL: logical, zero fill.
  - 111 SAR: arithmetic, MSB replicated.
- State machine has two states, IDLE and RUN.
- IDLE:
  - op_valid=1 with op 000–011: data updated on that same edge; done=1 for the following cycle.
  - NOP also pulses done; data unchanged.
  - op_valid=1 with op 1xx and amount=0: data unchanged, done pulses, stay in IDLE.
  - op_valid=1 with op 1xx and amount=n>0: latch op and n on edge k, go to RUN, busy=1 from edge k.
- RUN:
  - Each edge k+1..k+n moves data by exactly one bit position in the latched direction/mode and decrements the counter.
  - At edge k+n: return to IDLE, busy=0, done=1 for one cycle.
  - Total latency n+1 edges from accept to done.
- op_valid while busy=1: ignored entirely, no queueing. The requester must see busy=0 before issuing.
- Inputs i, op and amount are don't-care except at the accept edge; iterative ops use only the latched copies.
- done and busy are never both high in the same cycle. done is a single-cycle pulse even for back-to-back ops.
- Back-to-back requests:
  - A new op_valid is accepted on the edge where done is asserted, since the FSM is already in IDLE.
  - done then re-pulses per op.
- SHL/SAR by WIDTH-1 is legal and gives:
  - SHL: all-zero except bit WIDTH-1, which takes original bit 0.
  - SAR: all bits equal the original MSB.

Decomposition:
- Package register_ops_pkg holds:
  - op code localparams (OP_NOP..OP_SAR);
  - FSM state encoding (ST_IDLE, ST_RUN).
- Sub-module register_step_unit: combinational, WIDTH-parametrised.
  - Given op and current data, it produces the single-cycle result: reverse, swap, or one-step rotl/rotr/shl/sar.
  - The top instantiates it once and holds only the FSM, counter, register and handshake.

Test Plan:
- rst=1 for 2 edges with op_valid=1, op=LOAD, i=8'hFF -> data=8'h00, busy=0, done=0; no load occurs.
- LOAD i=8'hB4 -> data=8'hB4 after 1 edge, done high exactly 1 cycle.
- REVERSE on 8'hB4 -> 8'h2D.
- SWAP on 8'hB4 -> 8'h4B.
- WIDTH=16 instance: SWAP on 16'h12AB -> 16'hAB12.
- ROTL amount=3 on 8'hB4 -> busy high 3 cycles, data steps 8'h69, 8'hD2, 8'hA5, done pulses after 4th edge.
  - op_valid=LOAD mid-run -> ignored.
- SAR amount=2 on 8'h84 -> 8'hE1.
- SHL amount=0 -> data unchanged, done pulses after 1 edge, busy never rises.
- ROTR amount=5 on 8'h01, then rst asserted after the 2nd step -> data=8'h00, busy=0, and no done pulse.
